// File: rtl/fft_ctrl_pkg.sv
// Shared types and elaboration helpers for the FFT frame sequencer.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  // Each advance consumes a sample quartet across two lanes, so a frame is N/2 advances.
  function automatic int unsigned frame_cyc(input int unsigned n);
    return n / 2;
  endfunction

  function automatic int unsigned half_bit(input int unsigned half_period);
    return $clog2(half_period);
  endfunction

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Command and control/coefficient bus between the FFT host, sequencer and datapath.
interface fft_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              i_start;
  logic              i_valid;
  logic              i_abort;
  logic              o_ready;
  logic              o_busy;
  logic              o_twd;
  logic [ADDR_W-1:0] o_coeff0_addr;
  logic              o_coeff0_en;
  logic [ADDR_W-1:0] o_coeff1_addr;
  logic              o_stage2_en;
  logic              o_bfii_ctrl;
  logic              o_enable;
  logic              o_frame_done;

  modport master (
    output i_start, i_valid, i_abort,
    input  o_ready, o_busy, o_twd, o_coeff0_addr, o_coeff0_en,
           o_coeff1_addr, o_stage2_en, o_bfii_ctrl, o_enable, o_frame_done
  );

  modport slave (
    input  i_start, i_valid, i_abort,
    output o_ready, o_busy, o_twd, o_coeff0_addr, o_coeff0_en,
           o_coeff1_addr, o_stage2_en, o_bfii_ctrl, o_enable, o_frame_done
  );
endinterface

// File: rtl/fft_adv_counter.sv
// Wrap counter 0..MAX-1 with synchronous clear, advance and terminal-count flag.
module fft_adv_counter
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned W   = 5,
  parameter int unsigned MAX = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(MAX - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer for the two-lane pipelined FFT: one FSM driving both coefficient
// stages, twiddle/BFII control and the output-valid flag.
module fft_seq_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned N           = 64,
  parameter int unsigned HALF_PERIOD = 16,
  parameter int unsigned STAGE2_DLY  = 16,
  parameter int unsigned ADDR_W      = $clog2(N / 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_seq_ctrl_if.slave        bus
);

  localparam int unsigned       FRAME_CYC = frame_cyc(N);
  localparam int unsigned       TWD_BIT   = half_bit(HALF_PERIOD);
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(STAGE2_DLY - 1);

  seq_state_t        state, state_nxt;
  logic              adv1, adv2, clr, done_nxt;
  logic              enable_q, done_q;
  logic [ADDR_W-1:0] cnt1, cnt2;
  logic              tc1, tc2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      enable_q <= adv2;
      done_q   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    done_nxt  = 1'b0;
    adv1      = ((state == FILL) || (state == RUN)) && bus.i_valid;
    adv2      = ((state == RUN) && bus.i_valid) || (state == DRAIN);
    // Abort outranks everything, including a start arriving in IDLE.
    if (bus.i_abort) begin
      state_nxt = IDLE;
      clr       = 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.i_start) begin
          state_nxt = FILL;
          clr       = 1'b1;
        end
        FILL:  if (adv1 && (cnt1 == FILL_LAST)) state_nxt = RUN;
        RUN:   if (adv1 && tc1) state_nxt = DRAIN;
        DRAIN: if (tc2) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  fft_adv_counter #(.W(ADDR_W), .MAX(FRAME_CYC)) u_cnt1 (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .adv (adv1),
    .cnt (cnt1),
    .tc  (tc1)
  );

  fft_adv_counter #(.W(ADDR_W), .MAX(FRAME_CYC)) u_cnt2 (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .adv (adv2),
    .cnt (cnt2),
    .tc  (tc2)
  );

  assign bus.o_ready       = (state == IDLE);
  assign bus.o_busy        = (state != IDLE);
  assign bus.o_coeff0_addr = cnt1;
  assign bus.o_coeff1_addr = cnt2;
  assign bus.o_twd         = cnt1[TWD_BIT];
  assign bus.o_bfii_ctrl   = cnt2[TWD_BIT];
  assign bus.o_coeff0_en   = (state == FILL) || (state == RUN);
  assign bus.o_stage2_en   = (state == RUN) || (state == DRAIN);
  assign bus.o_enable      = enable_q;
  assign bus.o_frame_done  = done_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed self-checking bench for fft_seq_ctrl at default parameters (N=64).
module tb_fft_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fft_seq_ctrl_if #(.ADDR_W(5)) bus ();

  fft_seq_ctrl #(
    .N           (64),
    .HALF_PERIOD (16),
    .STAGE2_DLY  (16),
    .ADDR_W      (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"},  bus.o_ready, 1);
    check({tag, "_busy"},   bus.o_busy, 0);
    check({tag, "_addr0"},  bus.o_coeff0_addr, 0);
    check({tag, "_addr1"},  bus.o_coeff1_addr, 0);
    check({tag, "_twd"},    bus.o_twd, 0);
    check({tag, "_bfii"},   bus.o_bfii_ctrl, 0);
    check({tag, "_c0en"},   bus.o_coeff0_en, 0);
    check({tag, "_s2en"},   bus.o_stage2_en, 0);
    check({tag, "_enable"}, bus.o_enable, 0);
    check({tag, "_done"},   bus.o_frame_done, 0);
  endtask

  // t = cycles since the edge that sampled i_start, unstalled frame.
  task automatic check_frame_t(input string tag, input int t);
    int unsigned a0, a1;
    a0 = (t <= 31) ? t : 0;
    a1 = (t > 16 && t < 48) ? t - 16 : 0;
    check({tag, "_busy"},   bus.o_busy, (t < 48));
    check({tag, "_ready"},  bus.o_ready, (t >= 48));
    check({tag, "_addr0"},  bus.o_coeff0_addr, a0);
    check({tag, "_twd"},    bus.o_twd, (a0 >> 4) & 1);
    check({tag, "_addr1"},  bus.o_coeff1_addr, a1);
    check({tag, "_bfii"},   bus.o_bfii_ctrl, (a1 >> 4) & 1);
    check({tag, "_c0en"},   bus.o_coeff0_en, (t < 32));
    check({tag, "_s2en"},   bus.o_stage2_en, (t >= 16 && t < 48));
    check({tag, "_enable"}, bus.o_enable, (t >= 17 && t <= 48));
    check({tag, "_done"},   bus.o_frame_done, (t == 48));
  endtask

  task automatic run_full(input string tag);
    bus.i_start = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_abort = 1'b0;
    tick();
    bus.i_start = 1'b0;
    check_frame_t(tag, 0);
    for (int t = 1; t <= 48; t++) begin
      tick();
      check_frame_t(tag, t);
    end
  endtask

  task automatic run_count(input string tag, input int stall_at, input int stall_len,
                           input int drain_start_t, output int done_t, output int en_total);
    int t;
    bus.i_start = 1'b1;
    bus.i_valid = 1'b1;
    tick();
    bus.i_start = 1'b0;
    t        = 0;
    done_t   = -1;
    en_total = 0;
    while (t < 200 && done_t < 0) begin
      bus.i_valid = !(stall_len > 0 && t >= stall_at && t < stall_at + stall_len);
      bus.i_start = (t == drain_start_t);
      tick();
      t++;
      if (bus.o_enable) en_total++;
      if (stall_len > 0 && t > stall_at && t <= stall_at + stall_len)
        check({tag, "_freeze"}, bus.o_coeff0_addr, stall_at);
      if (stall_len > 0 && stall_at >= 16 && t == stall_at + 1)
        check({tag, "_en_drop"}, bus.o_enable, 0);
      if (bus.o_frame_done) done_t = t;
    end
    bus.i_start = 1'b0;
    bus.i_valid = 1'b1;
    if (done_t < 0) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int done_t, en_total, done_seen;
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_abort = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_idle("rst_hold");
    rst = 1'b1;
    repeat (5) begin
      tick();
      check_idle("idle");
    end

    run_full("frame1");
    run_full("b2b");
    tick();
    check_idle("after_b2b");

    run_count("stall_fill", 10, 5, -1, done_t, en_total);
    check("stall_fill_done_t", done_t, 53);
    check("stall_fill_en_total", en_total, 32);
    tick();

    run_count("stall_run", 20, 3, -1, done_t, en_total);
    check("stall_run_done_t", done_t, 51);
    check("stall_run_en_total", en_total, 32);
    tick();

    run_count("drain_start", 0, 0, 35, done_t, en_total);
    check("drain_start_done_t", done_t, 48);
    check("drain_start_en_total", en_total, 32);
    tick();
    check_idle("drain_start_ignored");

    // Abort in RUN once cnt2 reaches 4.
    bus.i_start = 1'b1;
    bus.i_valid = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (20) tick();
    check("abort_pre_addr1", bus.o_coeff1_addr, 4);
    check("abort_pre_s2en", bus.o_stage2_en, 1);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    check("abort_ready", bus.o_ready, 1);
    check("abort_busy", bus.o_busy, 0);
    check("abort_addr0", bus.o_coeff0_addr, 0);
    check("abort_addr1", bus.o_coeff1_addr, 0);
    check("abort_c0en", bus.o_coeff0_en, 0);
    check("abort_s2en", bus.o_stage2_en, 0);
    check("abort_done", bus.o_frame_done, 0);
    done_seen = 0;
    repeat (40) begin
      tick();
      if (bus.o_frame_done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check_idle("abort_settled");
    run_full("post_abort");
    tick();

    // Start and abort together in IDLE.
    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    check_idle("start_abort");
    tick();
    check_idle("start_abort_hold");

    // Asynchronous reset between edges while in DRAIN.
    bus.i_start = 1'b1;
    bus.i_valid = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (40) tick();
    check("pre_rst_s2en", bus.o_stage2_en, 1);
    check("pre_rst_enable", bus.o_enable, 1);
    #2;
    rst = 1'b0;
    #1;
    check_idle("async_rst");
    tick();
    rst = 1'b1;
    tick();
    check_idle("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_seq_ctrl.md
# fft_seq_ctrl

Frame sequencer for the two-lane pipelined FFT datapath. It accepts a start command, counts input sample cycles and drives the stage-1 twiddle toggle (`twd`), the stage-1 and stage-2 coefficient-memory addresses and enables, the BFII block control, and the output-valid flag. It replaces the free-running counters and the fixed enable delay with one FSM, so frames can stall, abort and run back to back. It sits beside the datapath top and feeds only its control and coefficient pins.

## Interface
- `N`, 64: FFT points per frame. Frame length `FRAME_CYC` = N/2 advance cycles.
- `HALF_PERIOD`, 16: advances per half-period of `twd` and `o_bfii_ctrl`. Must be a power of two.
- `STAGE2_DLY`, 16: stage-1 advances before stage 2 starts. Must be less than `FRAME_CYC`.
- `ADDR_W`, $clog2(N/2): coefficient address width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `i_start` in 1: frame start request, taken only while `o_ready` is high.
- `i_valid` in 1: current input sample quartet is valid.
- `i_abort` in 1: synchronous abort.
- `o_ready` out 1: high in IDLE.
- `o_busy` out 1: high whenever the state is not IDLE.
- `o_twd` out 1: stage-1 BFj twiddle select.
- `o_coeff0_addr` out ADDR_W: stage-1 coefficient address.
- `o_coeff0_en` out 1: stage-1 memory enable.
- `o_coeff1_addr` out ADDR_W: stage-2 coefficient address.
- `o_stage2_en` out 1: stage-2 memory enable.
- `o_bfii_ctrl` out 1: BFII block control.
- `o_enable` out 1: datapath output valid.
- `o_frame_done` out 1: one-cycle pulse at frame completion.

## Operation
- States: IDLE, FILL, RUN, DRAIN.
- Definitions:
  - adv1 = (FILL or RUN) and `i_valid`.
  - adv2 = (RUN and `i_valid`) or DRAIN.
- Counters:
  - cnt1 counts 0..FRAME_CYC-1 and increments on adv1.
  - cnt2 counts 0..FRAME_CYC-1 and increments on adv2.
  - Both counters clear on entry to FILL and on abort.
- Transitions:
  - IDLE→FILL on `i_start`.
  - FILL→RUN when adv1 occurs with cnt1 = STAGE2_DLY-1.
  - RUN→DRAIN when adv1 occurs with cnt1 = FRAME_CYC-1.
  - DRAIN→IDLE when cnt2 = FRAME_CYC-1 in DRAIN. `o_frame_done` pulses on that transition.
- Abort: `i_abort` forces any state to IDLE next cycle and clears counters. No `o_frame_done` pulse. If `i_abort` and `i_start` arrive together in IDLE, abort wins and the FSM stays in IDLE.
- Output mapping:
  - `o_coeff0_addr` = cnt1.
  - `o_twd` = cnt1 bit log2(HALF_PERIOD).
  - `o_coeff1_addr` = cnt2.
  - `o_bfii_ctrl` = cnt2 bit log2(HALF_PERIOD).
  - `o_coeff0_en` high in FILL and RUN.
  - `o_stage2_en` high in RUN and DRAIN.
- `o_enable` = adv2, registered. Across one full frame it is high for exactly FRAME_CYC cycles.
- Stall: `i_valid` low in FILL or RUN holds cnt1 and cnt2, and `o_enable` drops the following cycle. DRAIN ignores `i_valid`.
- `i_start` is ignored outside IDLE. The next frame can start in the cycle after `o_frame_done`.

## Timing
- All outputs are registered.
- Reset values: state IDLE, counters 0, `o_ready` 1, every other output 0.
- `i_start` sampled at edge k: `o_busy` is 1 and `o_ready` is 0 after edge k. The first `i_valid` counted is the one sampled at edge k+1.
- Addresses, `twd` and `o_bfii_ctrl` update in the cycle after the advance that changes the counter.
- `o_enable` lags adv2 by one cycle, so it lines up with the datapath's output register.
- Unstalled frame at defaults: FILL 16 cycles, RUN 16, DRAIN 16. `o_enable` is high from the cycle after RUN entry through the DRAIN→IDLE edge, 32 cycles in total.
- Reset asserted mid-frame: all outputs return to reset values immediately, with no clock required.

## Structure
- Shared package `fft_ctrl_pkg`:
  - state enum
  - FRAME_CYC calculation
  - bit-index helper for HALF_PERIOD
- One natural sub-module, `fft_adv_counter`: wrap counter with clear, advance and terminal-count flag. Instantiate it once per stage.
- Everything else stays in a single FSM plus output registers.

## Test plan
- Reset and idle: hold `rst`=0 for 3 cycles, then release → `o_ready`=1 and all other outputs 0 for 5 idle cycles.
- Full frame, `i_valid` always 1, defaults:
  - `o_coeff0_addr` runs 0..31.
  - `o_twd` toggles at addr 16.
  - `o_stage2_en` rises after 16 advances.
  - `o_enable` is high for 32 cycles.
  - `o_frame_done` pulses 48 cycles after start.
- Stall: drop `i_valid` for 5 cycles at cnt1=10 → addresses freeze at 10, frame_done is delayed by 5 cycles, and the `o_enable` total stays 32.
- Abort during RUN at cnt2=4 → IDLE the next cycle, counters 0, no `o_frame_done`. A following start produces a clean full frame.
- `i_start` and `i_abort` together in IDLE → stays IDLE. `i_start` in DRAIN → ignored. Back-to-back: start one cycle after done → second frame identical to the first.
- Asynchronous reset mid-DRAIN, asserted between clock edges → outputs clear before the next edge.
